drive_sequencer: RTL and testbench

- Downstream neighbour of the pattern buffer stage. Consumes its registered per-phase drive bytes and drives the output gate lines.
- Inserts programmable break-before-make dead time on every pwm transition.
- Applies the eight tweak-drive banks with delay/sense timing relative to the start of each drive phase.
- All outputs are registered; all gates are forced off during reset and dead time.

---
 rtl/drive_sequencer.sv | 131 +++++++++++++
 tb/tb_drive_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// Gate-drive sequencer: break-before-make dead time between pwm phases plus tweak-bank timing windows.
// Latency: pwm input to first gate change is 3 edges (pwm_q, state, output regs); no backpressure, inputs sampled every cycle.
module drive_sequencer #(
    parameter int buffer_width = 8,
    parameter int dead_w       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pwm,
    input  logic [dead_w-1:0]         dead_time,
    input  logic [buffer_width-1:0]   p_drive_in,
    input  logic [buffer_width-1:0]   n_drive_in,
    input  logic [buffer_width-1:0]   tweak_delay_in,
    input  logic [buffer_width-1:0]   tweak_sense_in,
    input  logic [8*buffer_width-1:0] tweak_drive_in,
    output logic [buffer_width-1:0]   p_gate,
    output logic [buffer_width-1:0]   n_gate,
    output logic [8*buffer_width-1:0] tweak_gate,
    output logic [1:0]                phase
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    localparam logic [dead_w-1:0] DCNT_ONE = {{(dead_w-1){1'b0}}, 1'b1};

    logic                      pwm_q;
    state_t                    state_q, state_d;
    logic                      target_q, target_d;
    logic [dead_w-1:0]         dcnt_q, dcnt_d;
    logic [7:0]                phase_cnt_q, phase_cnt_d;

    logic [buffer_width-1:0]   p_gate_q, p_gate_d;
    logic [buffer_width-1:0]   n_gate_q, n_gate_d;
    logic [8*buffer_width-1:0] tweak_gate_q, tweak_gate_d;
    logic [1:0]                phase_q, phase_d;

    logic                      active;
    logic [7:0]                tweak_delay;
    logic [7:0]                bank_en;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        dcnt_d      = dcnt_q;
        phase_cnt_d = phase_cnt_q;
        case (state_q)
            ST_OFF: begin
                state_d  = ST_DEAD;
                target_d = pwm_q;
                dcnt_d   = dead_time;
            end
            ST_HIGH, ST_LOW: begin
                if (pwm_q != target_q) begin
                    state_d  = ST_DEAD;
                    target_d = pwm_q;
                    dcnt_d   = dead_time;
                end else if (phase_cnt_q != 8'hFF) begin
                    phase_cnt_d = phase_cnt_q + 8'd1;
                end
            end
            ST_DEAD: begin
                // A pwm change inside dead time restarts the full interval toward the new target.
                if (pwm_q != target_q) begin
                    target_d = pwm_q;
                    dcnt_d   = dead_time;
                end else if (dcnt_q == '0) begin
                    state_d     = target_q ? ST_HIGH : ST_LOW;
                    phase_cnt_d = 8'd0;
                end else begin
                    dcnt_d = dcnt_q - DCNT_ONE;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_comb begin
        active       = (state_q == ST_HIGH) || (state_q == ST_LOW);
        tweak_delay  = tweak_delay_in[7:0];
        p_gate_d     = '1;
        n_gate_d     = '0;
        tweak_gate_d = '0;
        bank_en      = '0;
        phase_d      = state_q;
        if (state_q == ST_HIGH) p_gate_d = p_drive_in;
        if (state_q == ST_LOW)  n_gate_d = n_drive_in;
        // sense=1 selects the window before D, sense=0 the window from D onward.
        for (int k = 0; k < 8; k++) begin
            bank_en[k] = tweak_sense_in[k] ? (phase_cnt_q < tweak_delay)
                                           : (phase_cnt_q >= tweak_delay);
            if (active && bank_en[k])
                tweak_gate_d[k*buffer_width +: buffer_width] =
                    tweak_drive_in[k*buffer_width +: buffer_width];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q        <= 1'b0;
            state_q      <= ST_OFF;
            target_q     <= 1'b0;
            dcnt_q       <= '0;
            phase_cnt_q  <= 8'd0;
            p_gate_q     <= '1;
            n_gate_q     <= '0;
            tweak_gate_q <= '0;
            phase_q      <= 2'd0;
        end else begin
            pwm_q        <= pwm;
            state_q      <= state_d;
            target_q     <= target_d;
            dcnt_q       <= dcnt_d;
            phase_cnt_q  <= phase_cnt_d;
            p_gate_q     <= p_gate_d;
            n_gate_q     <= n_gate_d;
            tweak_gate_q <= tweak_gate_d;
            phase_q      <= phase_d;
        end
    end

    assign p_gate     = p_gate_q;
    assign n_gate     = n_gate_q;
    assign tweak_gate = tweak_gate_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Scoreboard bench for drive_sequencer: a phase-level model predicts every output cycle.
module tb_drive_sequencer;
    localparam int BW = 8;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            pwm = 1'b0;
    logic [DW-1:0]   dead_time = '0;
    logic [BW-1:0]   p_drive_in = '1, n_drive_in = '0;
    logic [BW-1:0]   tweak_delay_in = '0, tweak_sense_in = '0;
    logic [8*BW-1:0] tweak_drive_in = '0;
    logic [BW-1:0]   p_gate, n_gate;
    logic [8*BW-1:0] tweak_gate;
    logic [1:0]      phase;

    drive_sequencer #(.buffer_width(BW), .dead_w(DW)) dut (
        .clk(clk), .rst_n(rst_n), .pwm(pwm), .dead_time(dead_time),
        .p_drive_in(p_drive_in), .n_drive_in(n_drive_in),
        .tweak_delay_in(tweak_delay_in), .tweak_sense_in(tweak_sense_in),
        .tweak_drive_in(tweak_drive_in),
        .p_gate(p_gate), .n_gate(n_gate), .tweak_gate(tweak_gate), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0]   p;
        logic [BW-1:0]   n;
        logic [8*BW-1:0] tw;
        logic [1:0]      ph;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Model: mode 0=off 1=dead 2=high 3=low; 'left' = dead cycles still to burn after this one;
    // 'age' = cycles spent in the current drive phase, clamped at 255.
    int m_mode = 0, m_tgt = 0, m_left = 0, m_age = 0, m_seen = 0;

    function automatic exp_t predict();
        exp_t e;
        int   d;
        bit   en;
        e.p  = '1;
        e.n  = '0;
        e.tw = '0;
        e.ph = 2'(m_mode);
        if (m_mode >= 2) begin
            if (m_mode == 2) e.p = p_drive_in;
            else             e.n = n_drive_in;
            d = int'(tweak_delay_in[7:0]);
            for (int k = 0; k < 8; k++) begin
                en = tweak_sense_in[k] ? (m_age < d) : (m_age >= d);
                if (en) e.tw[k*BW +: BW] = tweak_drive_in[k*BW +: BW];
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        if (!rst_n) begin
            e    = '{p: '1, n: '0, tw: '0, ph: 2'd0};
            m_mode = 0; m_tgt = 0; m_left = 0; m_age = 0; m_seen = 0;
        end else begin
            e = predict();
            if (m_mode == 0 || (m_seen != m_tgt)) begin
                // entering or restarting dead time toward the latest sampled pwm
                m_mode = 1; m_tgt = m_seen; m_left = int'(dead_time);
            end else if (m_mode == 1) begin
                if (m_left == 0) begin
                    m_mode = (m_tgt == 1) ? 2 : 3;
                    m_age  = 0;
                end else m_left--;
            end else if (m_age < 255) m_age++;
            m_seen = int'(pwm);
        end
        exp_q.push_back(e);
    end

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("p_gate", 64'(p_gate), 64'(e.p));
            chk("n_gate", 64'(n_gate), 64'(e.n));
            chk("tweak_gate", tweak_gate, e.tw);
            chk("phase", 64'(phase), 64'(e.ph));
            chk("no_overlap", 64'((p_gate != '1) && (n_gate != '0)), 64'd0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        pwm            = 1'b1;
        dead_time      = 4'd2;
        p_drive_in     = 8'h5A;
        n_drive_in     = 8'h3C;
        tweak_delay_in = 8'd4;
        tweak_sense_in = 8'h0F;
        tweak_drive_in = '1;
        cycles(3);
        chk("reset_p_gate", 64'(p_gate), 64'hFF);
        chk("reset_n_gate", 64'(n_gate), 64'h00);
        chk("reset_tweak", tweak_gate, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2 chk("start_still_off", 64'(p_gate), 64'hFF);
        @(posedge clk);
        #2 chk("start_p_drive", 64'(p_gate), 64'h5A);

        cycles(12);
        tweak_delay_in = 8'd0;
        cycles(8);

        dead_time = 4'd3;
        pwm = 1'b0;
        cycles(14);
        pwm = 1'b1;
        cycles(14);

        dead_time = 4'd5;
        pwm = 1'b0;
        cycles(3);
        pwm = 1'b1;
        cycles(20);

        tweak_delay_in = 8'd255;
        tweak_sense_in = 8'h00;
        pwm = 1'b0;
        cycles(300);
        chk("sat_tweak_on", tweak_gate, '1);
        chk("sat_n_gate", 64'(n_gate), 64'h3C);

        #2 rst_n = 1'b0;
        #1;
        chk("async_n_gate", 64'(n_gate), 64'h00);
        chk("async_phase", 64'(phase), 64'd0);
        chk("async_tweak", tweak_gate, 64'd0);
        cycles(2);
        rst_n = 1'b1;

        for (int seg = 0; seg < 80; seg++) begin
            pwm            = 1'($urandom_range(0, 1));
            dead_time      = DW'($urandom_range(0, 15));
            p_drive_in     = BW'($urandom);
            n_drive_in     = BW'($urandom);
            tweak_delay_in = BW'($urandom_range(0, 12));
            tweak_sense_in = BW'($urandom);
            tweak_drive_in = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                cycles(2);
                rst_n = 1'b1;
            end
            for (int c = $urandom_range(1, 30); c > 0; c--) begin
                if ($urandom_range(0, 7) == 0) p_drive_in = BW'($urandom);
                if ($urandom_range(0, 7) == 0) n_drive_in = BW'($urandom);
                cycles(1);
            end
        end

        cycles(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
